// File: rtl/line_follow_ctrl.sv
// Line-sensor sequencer: synchronises and debounces the 3-bit sensor array,
// steers along the line and walks a parameterised junction route.
module line_follow_ctrl #(
  parameter int                     DEB_CYCLES   = 4,
  parameter int                     LOST_CYCLES  = 1000,
  parameter int                     TURN_TIMEOUT = 5000,
  parameter int                     NUM_JUNCT    = 4,
  parameter logic [2*NUM_JUNCT-1:0] ROUTE        = 8'b11_10_00_01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sensor,
  input  logic       start,
  input  logic       abort,
  output logic [2:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       lost,
  output logic [2:0] junction_cnt
);

  // state    | meaning
  // IDLE     | stopped, waiting for start
  // FOLLOW   | steering from the debounced pattern
  // CROSS    | driving straight over a junction until it clears
  // PIV_L1   | pivoting left, waiting for the centre sensor to leave the line
  // PIV_L2   | pivoting left, waiting for the centre sensor to find the line
  // PIV_R1/2 | as PIV_L1/2, pivoting right
  // DONE     | route finished
  // LOST     | line lost or turn timed out
  typedef enum logic [3:0] {
    S_IDLE, S_FOLLOW, S_CROSS, S_PIV_L1, S_PIV_L2,
    S_PIV_R1, S_PIV_R2, S_DONE, S_LOST
  } state_t;

  localparam logic [2:0] CMD_STOP    = 3'b000;
  localparam logic [2:0] CMD_FWD     = 3'b001;
  localparam logic [2:0] CMD_VEER_L  = 3'b010;
  localparam logic [2:0] CMD_VEER_R  = 3'b011;
  localparam logic [2:0] CMD_PIVOT_L = 3'b100;
  localparam logic [2:0] CMD_PIVOT_R = 3'b101;

  localparam int LW = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
  localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_TIMEOUT - 1);
  localparam logic [3:0]    DEB_THR   = 4'(DEB_CYCLES);

  logic [2:0]    sync1, sync2, cand, pat;
  logic [3:0]    deb_cnt, deb_nxt;
  state_t        state, state_nxt;
  logic [2:0]    jcnt_nxt, jcnt_inc;
  logic [1:0]    route_act;
  logic [LW-1:0] lost_cnt, lost_cnt_nxt;
  logic [TW-1:0] turn_cnt, turn_cnt_nxt;
  logic [2:0]    cmd_nxt, steer;
  logic          busy_nxt, done_nxt, lost_nxt;

  // deb_nxt counts consecutive identical synchroniser samples, including this one
  always_comb begin
    if (sync2 != cand)
      deb_nxt = 4'd1;
    else if (deb_cnt == 4'hf)
      deb_nxt = deb_cnt;
    else
      deb_nxt = deb_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 3'b000;
      sync2   <= 3'b000;
      cand    <= 3'b000;
      deb_cnt <= 4'd0;
      pat     <= 3'b000;
    end else begin
      sync1   <= sensor;
      sync2   <= sync1;
      cand    <= sync2;
      deb_cnt <= deb_nxt;
      if (deb_nxt >= DEB_THR)
        pat <= sync2;
    end
  end

  assign jcnt_inc = (junction_cnt == 3'd7) ? 3'd7 : junction_cnt + 3'd1;

  // Junctions past the end of the route behave as a stop entry.
  always_comb begin
    route_act = 2'b11;
    for (int i = 1; i <= NUM_JUNCT; i++)
      if (i <= 7 && jcnt_inc == 3'(i))
        route_act = ROUTE[2*i-2 +: 2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      junction_cnt <= 3'd0;
      lost_cnt     <= '0;
      turn_cnt     <= '0;
      cmd          <= CMD_STOP;
      busy         <= 1'b0;
      done         <= 1'b0;
      lost         <= 1'b0;
    end else begin
      state        <= state_nxt;
      junction_cnt <= jcnt_nxt;
      lost_cnt     <= lost_cnt_nxt;
      turn_cnt     <= turn_cnt_nxt;
      cmd          <= cmd_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      lost         <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    jcnt_nxt     = junction_cnt;
    lost_cnt_nxt = '0;
    turn_cnt_nxt = '0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_LOST: begin
          if (start) begin
            state_nxt = S_FOLLOW;
            jcnt_nxt  = 3'd0;
          end
        end
        S_FOLLOW: begin
          if (pat == 3'b111) begin
            jcnt_nxt = jcnt_inc;
            case (route_act)
              2'b00:   state_nxt = S_CROSS;
              2'b01:   state_nxt = S_PIV_L1;
              2'b10:   state_nxt = S_PIV_R1;
              default: state_nxt = S_DONE;
            endcase
          end else if (pat == 3'b000) begin
            if (lost_cnt == LOST_LAST)
              state_nxt = S_LOST;
            else
              lost_cnt_nxt = lost_cnt + LW'(1);
          end
        end
        S_CROSS: begin
          if (pat != 3'b111)
            state_nxt = S_FOLLOW;
        end
        // Turn timer spans both pivot phases; timeout wins over a phase change.
        S_PIV_L1, S_PIV_R1: begin
          turn_cnt_nxt = turn_cnt + TW'(1);
          if (turn_cnt == TURN_LAST)
            state_nxt = S_LOST;
          else if (!pat[1])
            state_nxt = (state == S_PIV_L1) ? S_PIV_L2 : S_PIV_R2;
        end
        S_PIV_L2, S_PIV_R2: begin
          turn_cnt_nxt = turn_cnt + TW'(1);
          if (turn_cnt == TURN_LAST)
            state_nxt = S_LOST;
          else if (pat[1])
            state_nxt = S_FOLLOW;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (pat)
      3'b010, 3'b101: steer = CMD_FWD;
      3'b110, 3'b100: steer = CMD_VEER_L;
      3'b011, 3'b001: steer = CMD_VEER_R;
      default:        steer = cmd;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    cmd_nxt  = CMD_STOP;
    busy_nxt = 1'b1;
    done_nxt = 1'b0;
    lost_nxt = 1'b0;
    case (state_nxt)
      S_FOLLOW:           cmd_nxt = steer;
      S_CROSS:            cmd_nxt = CMD_FWD;
      S_PIV_L1, S_PIV_L2: cmd_nxt = CMD_PIVOT_L;
      S_PIV_R1, S_PIV_R2: cmd_nxt = CMD_PIVOT_R;
      S_DONE: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end
      S_LOST: begin
        busy_nxt = 1'b0;
        lost_nxt = 1'b1;
      end
      default:            busy_nxt = 1'b0;
    endcase
  end

endmodule

// File: doc/line_follow_ctrl.md
# line_follow_ctrl

Sequencer for the rover's inductive line sensor array. It synchronises and debounces the 3-bit sensor pattern, steers along the line, and counts junctions. At each junction it executes a turn/straight/stop action from a parameterised route. Its command output drives the motor command decoder.

## Interface
- DEB_CYCLES, 4: consecutive stable cycles before a sensor pattern is accepted (1..15)
- LOST_CYCLES, 1000: consecutive accepted 000 cycles in FOLLOW before declaring lost
- TURN_TIMEOUT, 5000: maximum cycles in any pivot state before declaring lost
- NUM_JUNCT, 4: route length in junctions
- ROUTE, 8'b11_10_00_01: 2 bits per junction, junction 1 in bits [1:0]; 00 straight, 01 left, 10 right, 11 stop
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sensor  in  3  raw sensor; [2] left, [1] centre, [0] right; 1 = over line
- start  in  1  single-cycle pulse; begins a run from IDLE, DONE or LOST
- abort  in  1  single-cycle pulse; returns to IDLE from any state
- cmd  out  3  000 STOP, 001 FWD, 010 VEER_L, 011 VEER_R, 100 PIVOT_L, 101 PIVOT_R
- busy  out  1  high in every state except IDLE, DONE, LOST
- done  out  1  high while in DONE
- lost  out  1  high while in LOST
- junction_cnt  out  3  junctions passed in the current run; saturates at 7

## Operation
- Input path: 2-flop synchroniser, then debounce. The accepted pattern `pat` updates when the synchroniser output has held the same value for DEB_CYCLES consecutive cycles. `pat` resets to 000.
- States: IDLE, FOLLOW, CROSS, PIV_L1, PIV_L2, PIV_R1, PIV_R2, DONE, LOST.
- IDLE/DONE/LOST: cmd = STOP. On start: junction_cnt <= 0, then go to FOLLOW.
- FOLLOW steering from pat:
  - 010 or 101 -> FWD.
  - 110 or 100 -> VEER_L.
  - 011 or 001 -> VEER_R.
  - 000 -> hold previous cmd and increment the lost counter. The counter clears on any non-000 pat. When it reaches LOST_CYCLES, go to LOST.
- Junction: pat becomes 111 while in FOLLOW. Increment junction_cnt, index ROUTE with the new count, then:
  - 00 -> CROSS.
  - 01 -> PIV_L1.
  - 10 -> PIV_R1.
  - 11, or new count > NUM_JUNCT -> DONE.
- CROSS: cmd FWD until pat != 111, then FOLLOW. Prevents a single junction being counted twice.
- PIV_L1: cmd PIVOT_L until pat[1] = 0, then PIV_L2. PIV_L2: cmd PIVOT_L until pat[1] = 1, then FOLLOW.
- PIV_R1/PIV_R2: same as left, with PIVOT_R.
- Turn timer: clears on entry to PIV_x1 and runs across both pivot phases. Reaching TURN_TIMEOUT in either phase -> LOST.
- Precedence: abort beats start beats all other transitions. abort clears the counters but not junction_cnt.

## Timing
- Reset values: cmd 000, busy 0, done 0, lost 0, junction_cnt 0, state IDLE, all counters 0.
- All outputs are registered. cmd, busy, done and lost change on the same edge as the state change.
- Latency from a stable sensor change to a cmd change is exactly DEB_CYCLES + 3 rising edges: 2 synchroniser, DEB_CYCLES debounce, 1 output register.
- A glitch shorter than DEB_CYCLES cycles after synchronisation has no effect on pat.
- start to busy = 1: 1 cycle. start is ignored while busy.
- Asserting rst_n low mid-turn forces STOP immediately, without waiting for clk.
- junction_cnt saturates at 7 and never wraps.

## Test plan
- FOLLOW steering: start, then hold sensor 010 -> cmd FWD 7 cycles after the sensor settles. Switch to 110 -> VEER_L 7 cycles later. A 3-cycle 001 glitch -> cmd unchanged.
- Default route:
  - 111 -> junction_cnt 1, PIVOT_L; then 000, then 010 -> FOLLOW.
  - Second 111 -> junction_cnt 2, cmd stays FWD through CROSS.
  - Third 111 -> PIVOT_R.
  - Fourth 111 -> DONE, done = 1, cmd STOP, busy 0.
- Lost: in FOLLOW hold 000 -> lost = 1 and cmd STOP exactly LOST_CYCLES cycles after pat becomes 000. 000 for 999 cycles then 010 -> no lost.
- Turn timeout: enter PIV_L1 and hold 111 -> lost = 1 after 5000 cycles. Then pulse start -> FOLLOW, junction_cnt 0.
- Abort and reset: abort and start together in PIV_R2 -> IDLE, cmd STOP. Assert rst_n low mid-CROSS -> all outputs at reset values with no clock edge.
